cycle_datapath: RTL
===================

// Module: cycle_datapath
// PURPOSE
//  Datapath side of the fetch/decode/execute phase protocol. Consumes the one-hot phase strobes
//  from the instruction-cycle control unit and performs each phase: instruction fetch from a
//  synchronous memory, decode into opcode/operand, and execution on an accumulator with Z/C flags.
//  Checks that strobes arrive in legal order and flags protocol violations.
// PARAMETERS
//  DATA_W   8   accumulator, operand and out_data width
//  ADDR_W   8   program counter / memory address width (ADDR_W <= DATA_W)
//  OP_W     4   opcode width; INSTR_W = OP_W+DATA_W (derived localparam, not overridable)
// PORTS
//  clk        in   1        single clock, rising edge
//  reset      in   1        synchronous, active-high
//  fetch      in   1        phase strobe from control unit
//  decode     in   1        phase strobe
//  execute    in   1        phase strobe
//  mem_rd     out  1        memory read enable (combinational: accepted fetch)
//  mem_addr   out  ADDR_W   read address (= pc register)
//  mem_rdata  in   INSTR_W  read data, valid in the cycle after mem_rd; {opcode, operand}
//  pc         out  ADDR_W   program counter
//  acc        out  DATA_W   accumulator
//  flag_z     out  1        zero flag
//  flag_c     out  1        carry/borrow flag
//  out_valid  out  1        1-cycle pulse, out_data valid
//  out_data   out  DATA_W   acc value captured by OUT
//  illegal_op out  1        1-cycle pulse on execute of an undefined opcode
//  phase_err  out  1        sticky; cleared only by reset
// BEHAVIOUR
//  - Reset: pc, acc, ir, out_data = 0; flag_z=1; flag_c, out_valid, illegal_op, phase_err = 0;
//    phase tracker = EXP_FETCH. All outputs except mem_rd/mem_addr are registered.
//  - Tracker states EXP_FETCH -> EXP_DECODE -> EXP_EXEC -> EXP_FETCH.
//    fetch is accepted in any state (resynchronises, -> EXP_DECODE); decode only in EXP_DECODE;
//    execute only in EXP_EXEC. Out-of-order strobe: ignored, phase_err<=1, tracker unchanged.
//    Two or more strobes in one cycle: all ignored, phase_err<=1, tracker -> EXP_FETCH.
//    No strobe: hold all state.
//  - Fetch: mem_rd=1 in the strobe cycle, mem_addr=pc. In the next cycle ir <= mem_rdata
//    unconditionally (1-cycle memory latency, independent of following strobes).
//  - Decode: pc <= pc+1, wraps 2^ADDR_W-1 -> 0. op/operand registered from ir.
//  - Execute (result visible the cycle after the strobe):
//    0 NOP; 1 LDI acc=imm; 2 ADD acc=acc+imm, C=carry out of bit DATA_W-1;
//    3 SUB acc=acc-imm, C=1 iff acc<imm (borrow); 4 AND; 5 OR; 6 XOR (logic ops clear C);
//    7 JMP pc=imm[ADDR_W-1:0]; 8 JZ pc=imm[ADDR_W-1:0] iff Z=1; 9 OUT out_valid=1, out_data=acc.
//    Z=(result==0) updated by LDI and ALU ops only; JMP/JZ/OUT/NOP leave flags unchanged.
//    Opcodes 10..15: no state change, illegal_op pulses for one cycle.
//  - Arithmetic modulo 2^DATA_W; no saturation. Jump target overrides the decode increment.
//  - Reset mid-cycle: reset has priority over every strobe; pending ir capture is discarded.
// STRUCTURE
//  - Package cycle_pkg: opcode constants OP_NOP..OP_OUT, OP_W, tracker state encodings.
//  - Sub-module cycle_alu (combinational): op, a, b -> result, carry, zero; shared by ADD..XOR/LDI.
//  - Top holds tracker FSM, pc/ir/acc/flag registers, output pulse registers.
// TESTING
//  1 Reset, repeat fetch/decode/execute over mem {LDI 5, ADD 3, OUT} -> out_valid once, out_data=8, pc=3.
//  2 acc=0xFF, ADD 1 -> acc=0x00, Z=1, C=1; then SUB 1 -> acc=0xFF, C=1, Z=0.
//  3 LDI 0 then JZ 0x20 -> pc=0x20 after execute; LDI 1 then JZ 0x20 -> pc=prior pc+1.
//  4 pc=0xFF, fetch+decode -> pc=0x00; execute JMP 0x10 -> pc=0x10.
//  5 decode without prior fetch -> phase_err=1, pc/acc unchanged; fetch+execute together -> ignored,
//    next decode rejected, next fetch accepted (mem_rd=1).
//  6 Opcode 0xC executed -> illegal_op single-cycle pulse, acc/flags/pc unchanged; reset
//    asserted between fetch and decode -> all regs at reset values, phase_err=0.

Source files
------------

// File: rtl/cycle_pkg.sv
// Shared constants for the instruction-cycle datapath: opcodes, phase tracker
// states and the ALU function select.
package cycle_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 4'd0,
        OP_LDI = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_JMP = 4'd7,
        OP_JZ  = 4'd8,
        OP_OUT = 4'd9
    } opcode_e;

    typedef enum logic [1:0] {
        EXP_FETCH,
        EXP_DECODE,
        EXP_EXEC
    } phase_e;

    typedef enum logic [2:0] {
        ALU_PASS,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR
    } alu_fn_e;

endpackage

// File: rtl/cycle_alu.sv
// Combinational ALU shared by LDI and the arithmetic/logic opcodes.
// carry is the carry-out for ADD, the borrow for SUB and zero otherwise.
module cycle_alu
    import cycle_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  alu_fn_e           fn,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] wide;

    // One extra bit holds carry-out on add and the borrow on subtract.
    always_comb begin
        wide = '0;
        case (fn)
            ALU_ADD: wide = {1'b0, a} + {1'b0, b};
            ALU_SUB: wide = {1'b0, a} - {1'b0, b};
            ALU_AND: wide = {1'b0, a & b};
            ALU_OR:  wide = {1'b0, a | b};
            ALU_XOR: wide = {1'b0, a ^ b};
            default: wide = {1'b0, b};
        endcase
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
        zero   = (wide[DATA_W-1:0] == '0);
    end

endmodule

// File: rtl/cycle_datapath.sv
// Datapath for the fetch/decode/execute phase protocol: tracks strobe order,
// fetches from a 1-cycle-latency memory, decodes and executes on the accumulator.
module cycle_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int OP_W   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch,
    input  logic                   decode,
    input  logic                   execute,
    output logic                   mem_rd,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [OP_W+DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0]      pc,
    output logic [DATA_W-1:0]      acc,
    output logic                   flag_z,
    output logic                   flag_c,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic                   illegal_op,
    output logic                   phase_err
);

    import cycle_pkg::*;

    localparam int INSTR_W = OP_W + DATA_W;

    phase_e             state_q, state_d;
    logic [1:0]         strobe_cnt;
    logic               multi, do_fetch, do_decode, do_exec, strobe_err;
    logic               fetch_pending;
    logic [INSTR_W-1:0] ir_q, ir_next;
    logic [OP_W-1:0]    op_q;
    logic [DATA_W-1:0]  imm_q;
    alu_fn_e            alu_fn;
    logic               wr_acc, wr_c, do_jump, fire_out, bad_op;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_carry, alu_zero;

    assign strobe_cnt = {1'b0, fetch} + {1'b0, decode} + {1'b0, execute};
    assign multi      = (strobe_cnt > 2'd1);

    always_ff @(posedge clk) begin
        if (reset) state_q <= EXP_FETCH;
        else       state_q <= state_d;
    end

    // fetch always resynchronises; colliding strobes drop back to EXP_FETCH.
    always_comb begin
        state_d = state_q;
        if (multi)                                 state_d = EXP_FETCH;
        else if (fetch)                            state_d = EXP_DECODE;
        else if (decode && state_q == EXP_DECODE)  state_d = EXP_EXEC;
        else if (execute && state_q == EXP_EXEC)   state_d = EXP_FETCH;
    end

    always_comb begin
        do_fetch   = fetch && !multi;
        do_decode  = decode && !multi && (state_q == EXP_DECODE);
        do_exec    = execute && !multi && (state_q == EXP_EXEC);
        strobe_err = multi
                  || (decode && !multi && (state_q != EXP_DECODE))
                  || (execute && !multi && (state_q != EXP_EXEC));
    end

    assign mem_rd   = do_fetch && !reset;
    assign mem_addr = pc;

    // A decode right after fetch must see the word arriving this cycle.
    assign ir_next = fetch_pending ? mem_rdata : ir_q;

    always_comb begin
        alu_fn   = ALU_PASS;
        wr_acc   = 1'b0;
        wr_c     = 1'b0;
        do_jump  = 1'b0;
        fire_out = 1'b0;
        bad_op   = 1'b0;
        case (op_q)
            OP_W'(OP_NOP): begin end
            OP_W'(OP_LDI): wr_acc = 1'b1;
            OP_W'(OP_ADD): begin alu_fn = ALU_ADD; wr_acc = 1'b1; wr_c = 1'b1; end
            OP_W'(OP_SUB): begin alu_fn = ALU_SUB; wr_acc = 1'b1; wr_c = 1'b1; end
            OP_W'(OP_AND): begin alu_fn = ALU_AND; wr_acc = 1'b1; wr_c = 1'b1; end
            OP_W'(OP_OR):  begin alu_fn = ALU_OR;  wr_acc = 1'b1; wr_c = 1'b1; end
            OP_W'(OP_XOR): begin alu_fn = ALU_XOR; wr_acc = 1'b1; wr_c = 1'b1; end
            OP_W'(OP_JMP): do_jump = 1'b1;
            OP_W'(OP_JZ):  do_jump = flag_z;
            OP_W'(OP_OUT): fire_out = 1'b1;
            default:       bad_op = 1'b1;
        endcase
    end

    cycle_alu #(.DATA_W(DATA_W)) u_alu (
        .fn     (alu_fn),
        .a      (acc),
        .b      (imm_q),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= '0;
            acc           <= '0;
            flag_z        <= 1'b1;
            flag_c        <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            illegal_op    <= 1'b0;
            phase_err     <= 1'b0;
            fetch_pending <= 1'b0;
            ir_q          <= '0;
            op_q          <= '0;
            imm_q         <= '0;
        end else begin
            out_valid     <= 1'b0;
            illegal_op    <= 1'b0;
            fetch_pending <= do_fetch;
            if (fetch_pending) ir_q <= mem_rdata;
            if (strobe_err) phase_err <= 1'b1;
            if (do_decode) begin
                pc    <= pc + ADDR_W'(1);
                op_q  <= ir_next[INSTR_W-1 -: OP_W];
                imm_q <= ir_next[DATA_W-1:0];
            end
            if (do_exec) begin
                if (wr_acc) begin
                    acc    <= alu_result;
                    flag_z <= alu_zero;
                end
                if (wr_c)    flag_c <= alu_carry;
                if (do_jump) pc <= imm_q[ADDR_W-1:0];
                if (fire_out) begin
                    out_valid <= 1'b1;
                    out_data  <= acc;
                end
                if (bad_op) illegal_op <= 1'b1;
            end
        end
    end

endmodule
